// File: rtl/alarm_trigger_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alarm_trigger_ctrl
// Purpose  : Counts consecutive failed code attempts. After MAX_FAIL failures
//            it raises alarm for ALARM_SEC ticks, then enforces a silent
//            lockout of LOCK_SEC ticks. A successful code in IDLE produces a
//            one-cycle unlock pulse and clears the failure count.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            check_valid  - one-cycle pulse, a code compare result is ready
//            check_ok     - compare result (1 = match), qualified by check_valid
//            admin_clear  - abort alarm/lockout and clear the failure count
//            alarm        - drive to LED/buzzer, high while alarming
//            locked       - high while attempts are rejected (ALARM or LOCK)
//            unlock       - one-cycle pulse, valid code accepted
//            fail_cnt     - current consecutive-failure count
// Revision : 1.0 - initial release
// ============================================================================
module alarm_trigger_ctrl #(
    parameter int unsigned MAX_FAIL  = 3,
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned ALARM_SEC = 10,
    parameter int unsigned LOCK_SEC  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       check_valid,
    input  logic       check_ok,
    input  logic       admin_clear,
    output logic       alarm,
    output logic       locked,
    output logic       unlock,
    output logic [3:0] fail_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [31:0] c_tick_last  = 32'(TICK_DIV - 1);
    localparam logic [7:0]  c_alarm_last = 8'(ALARM_SEC - 1);
    // Only meaningful when LOCK_SEC > 0; the LOCK state is unreachable otherwise.
    localparam logic [7:0]  c_lock_last  = 8'(LOCK_SEC - 1);
    localparam logic        c_lock_en    = (LOCK_SEC != 0);
    localparam logic [3:0]  c_max_fail   = 4'(MAX_FAIL);

    state_t      state_q,    state_d;
    logic [31:0] tick_q,     tick_d;
    logic [7:0]  sec_q,      sec_d;
    logic [3:0]  fail_cnt_q, fail_cnt_d;
    logic        alarm_q,    alarm_d;
    logic        locked_q,   locked_d;
    logic        unlock_q,   unlock_d;

    logic        w_tick_wrap;
    logic [4:0]  w_fail_inc;

    assign w_tick_wrap = (tick_q == c_tick_last);
    // One bit wider so the comparison against MAX_FAIL can never wrap.
    assign w_fail_inc  = {1'b0, fail_cnt_q} + 5'd1;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        sec_d      = sec_q;
        fail_cnt_d = fail_cnt_q;
        alarm_d    = alarm_q;
        locked_d   = locked_q;
        unlock_d   = 1'b0;

        if (admin_clear) begin
            // Highest priority: any coincident attempt is dropped.
            state_d    = IDLE;
            tick_d     = '0;
            sec_d      = '0;
            fail_cnt_d = '0;
            alarm_d    = 1'b0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (check_valid) begin
                        if (check_ok) begin
                            fail_cnt_d = '0;
                            unlock_d   = 1'b1;
                        end else if (w_fail_inc < {1'b0, c_max_fail}) begin
                            fail_cnt_d = w_fail_inc[3:0];
                        end else begin
                            fail_cnt_d = c_max_fail;
                            state_d    = ALARM;
                            alarm_d    = 1'b1;
                            locked_d   = 1'b1;
                            tick_d     = '0;
                            sec_d      = '0;
                        end
                    end
                end

                ALARM: begin
                    // Expiry is the last tick of the last second, so the
                    // state lasts exactly ALARM_SEC*TICK_DIV cycles.
                    if (w_tick_wrap && (sec_q == c_alarm_last)) begin
                        alarm_d = 1'b0;
                        tick_d  = '0;
                        sec_d   = '0;
                        if (c_lock_en) begin
                            state_d = LOCK;
                        end else begin
                            state_d    = IDLE;
                            locked_d   = 1'b0;
                            fail_cnt_d = '0;
                        end
                    end else if (w_tick_wrap) begin
                        tick_d = '0;
                        sec_d  = sec_q + 8'd1;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end

                LOCK: begin
                    if (w_tick_wrap && (sec_q == c_lock_last)) begin
                        state_d    = IDLE;
                        locked_d   = 1'b0;
                        fail_cnt_d = '0;
                        tick_d     = '0;
                        sec_d      = '0;
                    end else if (w_tick_wrap) begin
                        tick_d = '0;
                        sec_d  = sec_q + 8'd1;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean IDLE.
                    state_d    = IDLE;
                    tick_d     = '0;
                    sec_d      = '0;
                    fail_cnt_d = '0;
                    alarm_d    = 1'b0;
                    locked_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            sec_q      <= '0;
            fail_cnt_q <= '0;
            alarm_q    <= 1'b0;
            locked_q   <= 1'b0;
            unlock_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            fail_cnt_q <= fail_cnt_d;
            alarm_q    <= alarm_d;
            locked_q   <= locked_d;
            unlock_q   <= unlock_d;
        end
    end

    assign alarm    = alarm_q;
    assign locked   = locked_q;
    assign unlock   = unlock_q;
    assign fail_cnt = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_trigger_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alarm_trigger_ctrl
// Purpose  : Self-checking bench for alarm_trigger_ctrl. Two instances share
//            the stimulus: one with a lockout phase, one with LOCK_SEC=0.
//            A remaining-cycles model per instance predicts every output.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_trigger_ctrl;

    localparam int TD = 4;
    localparam int AS = 2;
    localparam int LS = 3;
    localparam int MF = 3;

    logic       clk;
    logic       rst_n;
    logic       check_valid;
    logic       check_ok;
    logic       admin_clear;
    logic       alarm0, locked0, unlock0;
    logic [3:0] fail0;
    logic       alarm1, locked1, unlock1;
    logic [3:0] fail1;

    int checks = 0;
    int errors = 0;

    // mode: 0 idle, 1 alarm, 2 lock; rem: cycles left in the current mode
    typedef struct {
        int mode;
        int rem;
        int fail;
        bit unl;
    } model_t;

    model_t m0, m1;

    alarm_trigger_ctrl #(.MAX_FAIL(MF), .TICK_DIV(TD), .ALARM_SEC(AS), .LOCK_SEC(LS)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .check_valid(check_valid), .check_ok(check_ok),
        .admin_clear(admin_clear), .alarm(alarm0), .locked(locked0),
        .unlock(unlock0), .fail_cnt(fail0)
    );

    alarm_trigger_ctrl #(.MAX_FAIL(MF), .TICK_DIV(TD), .ALARM_SEC(AS), .LOCK_SEC(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .check_valid(check_valid), .check_ok(check_ok),
        .admin_clear(admin_clear), .alarm(alarm1), .locked(locked1),
        .unlock(unlock1), .fail_cnt(fail1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t nxt(model_t m, bit cv, bit ok, bit clr, int lsec);
        model_t r;
        r     = m;
        r.unl = 1'b0;
        if (clr) begin
            r.mode = 0; r.rem = 0; r.fail = 0;
        end else if (m.mode == 1) begin
            r.rem = m.rem - 1;
            if (r.rem == 0) begin
                if (lsec > 0) begin
                    r.mode = 2; r.rem = lsec * TD;
                end else begin
                    r.mode = 0; r.fail = 0;
                end
            end
        end else if (m.mode == 2) begin
            r.rem = m.rem - 1;
            if (r.rem == 0) begin
                r.mode = 0; r.fail = 0;
            end
        end else if (cv) begin
            if (ok) begin
                r.fail = 0; r.unl = 1'b1;
            end else if (m.fail + 1 < MF) begin
                r.fail = m.fail + 1;
            end else begin
                r.fail = MF; r.mode = 1; r.rem = AS * TD;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '{0, 0, 0, 1'b0};
            m1 <= '{0, 0, 0, 1'b0};
        end else begin
            m0 <= nxt(m0, check_valid, check_ok, admin_clear, LS);
            m1 <= nxt(m1, check_valid, check_ok, admin_clear, 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("u0.alarm",    int'(alarm0),  int'(m0.mode == 1));
        chk("u0.locked",   int'(locked0), int'(m0.mode != 0));
        chk("u0.unlock",   int'(unlock0), int'(m0.unl));
        chk("u0.fail_cnt", int'(fail0),   m0.fail);
        chk("u1.alarm",    int'(alarm1),  int'(m1.mode == 1));
        chk("u1.locked",   int'(locked1), int'(m1.mode != 0));
        chk("u1.unlock",   int'(unlock1), int'(m1.unl));
        chk("u1.fail_cnt", int'(fail1),   m1.fail);
    end

    // Inputs change 1 ns after the rising edge and are sampled on the next one.
    task automatic drive(input bit cv, input bit ok, input bit clr);
        @(posedge clk);
        #1;
        check_valid = cv;
        check_ok    = ok;
        admin_clear = clr;
    endtask

    task automatic pulse(input bit ok);
        drive(1'b1, ok, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic resync();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Counts cycles (including the current one) that sig_sel stays high on u0.
    // sel: 0 = alarm0, 1 = locked0. with_ok injects passing checks.
    task automatic count_high(input int sel, input bit with_ok, output int n);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            drive(with_ok && (k % 3 == 0), 1'b1, 1'b0);
            if ((sel == 0) ? alarm0 : locked0) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; check_valid = 1'b0; check_ok = 1'b0; admin_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_alarm", int'(alarm0), 0);
        chk("reset_locked", int'(locked0), 0);
        chk("reset_fail_cnt", int'(fail0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two failures then a pass
        pulse(1'b0);
        chk("fail_cnt_after_1", int'(fail0), 1);
        pulse(1'b0);
        chk("fail_cnt_after_2", int'(fail0), 2);
        pulse(1'b1);
        chk("unlock_after_pass", int'(unlock0), 1);
        chk("fail_cnt_after_pass", int'(fail0), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("unlock_one_cycle", int'(unlock0), 0);
        chk("alarm_stays_low", int'(alarm0), 0);

        // Three failures: alarm 8 cycles, lock 12 cycles
        pulse(1'b0); pulse(1'b0); pulse(1'b0);
        chk("alarm_rise", int'(alarm0), 1);
        chk("locked_rise", int'(locked0), 1);
        count_high(0, 1'b0, n);
        chk("alarm_cycles", n, AS * TD);
        chk("nolock_locked_falls_with_alarm", int'(locked1), 0);
        chk("nolock_fail_cnt_cleared", int'(fail1), 0);
        chk("locked_after_alarm", int'(locked0), 1);
        count_high(1, 1'b0, n);
        chk("lock_cycles", n, LS * TD);
        chk("fail_cnt_after_lock", int'(fail0), 0);
        resync();

        // Passing checks during ALARM and LOCK change nothing
        pulse(1'b0); pulse(1'b0); pulse(1'b0);
        count_high(0, 1'b1, n);
        chk("alarm_cycles_with_ok", n, AS * TD);
        count_high(1, 1'b1, n);
        chk("lock_cycles_with_ok", n, LS * TD);
        resync();

        // admin_clear in the 4th ALARM cycle together with a passing check
        pulse(1'b0); pulse(1'b0); pulse(1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("clr_alarm", int'(alarm0), 0);
        chk("clr_locked", int'(locked0), 0);
        chk("clr_fail_cnt", int'(fail0), 0);
        chk("clr_unlock", int'(unlock0), 0);
        resync();

        // Asynchronous reset mid-ALARM
        pulse(1'b0); pulse(1'b0); pulse(1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_alarm", int'(alarm0), 0);
        chk("arst_locked", int'(locked0), 0);
        chk("arst_fail_cnt", int'(fail0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b0);
        chk("arst_then_fail_cnt", int'(fail0), 1);
        chk("arst_then_alarm", int'(alarm0), 0);
        resync();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 63) == 0));
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
